// File: rtl/immediate_narrowing.sv
// Narrows an M-bit datapath value to an N-bit immediate and flags representability.
// Results are buffered in a small in-order FIFO; non-fitting accepts are counted.
module immediate_narrowing #(
  parameter int N     = 16,
  parameter int M     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     immediateIN,
  input  logic             U,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     immediateOUT,
  output logic             fits,
  output logic [CNT_W-1:0] overflow_count,
  input  logic             clr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  logic [N:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;

  logic         push;
  logic         pop;
  logic         fit_w;
  logic [M-N:0] sgn_bits;
  logic [N:0]   head;

  assign sgn_bits = immediateIN[M-1:N-1];

  always_comb begin
    fit_w = 1'b0;
    if (U) fit_w = ~(|immediateIN[M-1:N]);
    else   fit_w = (&sgn_bits) | ~(|sgn_bits);
  end

  assign out_valid = (occ_q != '0);
  assign in_ready  = rst_n && (occ_q < FULL);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // clear wins over a same-cycle increment; saturate at all-ones
  always_comb begin
    ovf_d = ovf_q;
    if (clr_count) begin
      ovf_d = '0;
    end else if (push && !fit_w && (ovf_q != '1)) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {fit_w, immediateIN[N-1:0]};
  end

  assign head           = mem_q[rd_ptr_q];
  assign immediateOUT   = out_valid ? head[N-1:0] : '0;
  assign fits           = out_valid & head[N];
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_immediate_narrowing.sv
// Directed bench for immediate_narrowing: narrowing, FIFO order/backpressure,
// counter saturation/clear and mid-run reset.
module tb_immediate_narrowing;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] immediateIN;
  logic        U;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] immediateOUT;
  logic        fits;
  logic [7:0]  overflow_count;
  logic        clr_count;

  int n_chk  = 0;
  int n_fail = 0;

  immediate_narrowing #(.N(16), .M(32), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .immediateIN(immediateIN),
    .U(U),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .immediateOUT(immediateOUT),
    .fits(fits),
    .overflow_count(overflow_count),
    .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic u, input logic [31:0] d);
    in_valid    = v;
    U           = u;
    immediateIN = d;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_count = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    cyc();
    cyc();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_imm", 32'(immediateOUT), 32'h0);
    chk("rst_fits", 32'(fits), 32'h0);
    chk("rst_cnt", 32'(overflow_count), 32'h0);
    chk("rst_in_ready_low", 32'(in_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // unsigned fitting value, one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 32'h0000000A);
    cyc();
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_imm", 32'(immediateOUT), 32'h000A);
    chk("t1_fits", 32'(fits), 32'h1);
    chk("t1_cnt", 32'(overflow_count), 32'h0);

    // signed: sign-extended negative fits, positive with bit15 set does not
    drive(1'b1, 1'b0, 32'hFFFF800A);
    cyc();
    chk("t2a_imm", 32'(immediateOUT), 32'h800A);
    chk("t2a_fits", 32'(fits), 32'h1);
    drive(1'b1, 1'b0, 32'h0000800A);
    cyc();
    chk("t2b_imm", 32'(immediateOUT), 32'h800A);
    chk("t2b_fits", 32'(fits), 32'h0);
    chk("t2b_cnt", 32'(overflow_count), 32'h1);

    // unsigned: bit16 set overflows, full 16-bit value fits
    drive(1'b1, 1'b1, 32'h00011E1F);
    cyc();
    chk("t3a_imm", 32'(immediateOUT), 32'h1E1F);
    chk("t3a_fits", 32'(fits), 32'h0);
    chk("t3a_cnt", 32'(overflow_count), 32'h2);
    drive(1'b1, 1'b1, 32'h0000FE1F);
    cyc();
    chk("t3b_imm", 32'(immediateOUT), 32'hFE1F);
    chk("t3b_fits", 32'(fits), 32'h1);
    chk("t3b_cnt", 32'(overflow_count), 32'h2);
    drive(1'b0, 1'b0, 32'hDEADBEEF);
    cyc();
    chk("t3_empty_valid", 32'(out_valid), 32'h0);
    chk("t3_empty_imm", 32'(immediateOUT), 32'h0);
    chk("t3_empty_fits", 32'(fits), 32'h0);

    // fill with backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 32'(i));
      cyc();
    end
    chk("t4_full_in_ready", 32'(in_ready), 32'h0);
    chk("t4_full_head", 32'(immediateOUT), 32'h0001);
    drive(1'b1, 1'b1, 32'h5);
    cyc();
    chk("t4_still_full", 32'(in_ready), 32'h0);
    chk("t4_head_stable", 32'(immediateOUT), 32'h0001);
    chk("t4_head_fits", 32'(fits), 32'h1);
    drive(1'b0, 1'b0, 32'h0);
    out_ready = 1'b1;
    #1;
    chk("t4_no_passthru", 32'(in_ready), 32'h0);
    cyc();
    chk("t4_ready_after_pop", 32'(in_ready), 32'h1);
    chk("t4_head2", 32'(immediateOUT), 32'h0002);
    cyc();
    chk("t4_head3", 32'(immediateOUT), 32'h0003);
    cyc();
    chk("t4_head4", 32'(immediateOUT), 32'h0004);
    cyc();
    chk("t4_drained", 32'(out_valid), 32'h0);

    // saturation: count starts at 2
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, 32'h00010000);
      cyc();
    end
    chk("t5_cnt_102", 32'(overflow_count), 32'd102);
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b1, 32'h00010000);
      cyc();
    end
    chk("t5_cnt_sat", 32'(overflow_count), 32'd255);
    clr_count = 1'b1;
    drive(1'b1, 1'b0, 32'h00010000);
    cyc();
    chk("t5_clr_prio", 32'(overflow_count), 32'h0);
    clr_count = 1'b0;
    drive(1'b1, 1'b0, 32'h00010000);
    cyc();
    chk("t5_cnt_after_clr", 32'(overflow_count), 32'h1);
    drive(1'b0, 1'b0, 32'h0);
    cyc();
    chk("t5_drained", 32'(out_valid), 32'h0);

    // reset with buffered entries
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h21 + 32'(i));
      cyc();
    end
    chk("t6_filled", 32'(out_valid), 32'h1);
    drive(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    cyc();
    chk("t6_rst_valid", 32'(out_valid), 32'h0);
    chk("t6_rst_cnt", 32'(overflow_count), 32'h0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    cyc();
    chk("t6_no_stale", 32'(out_valid), 32'h0);
    drive(1'b1, 1'b1, 32'h00000055);
    cyc();
    chk("t6_fresh_imm", 32'(immediateOUT), 32'h0055);
    drive(1'b0, 1'b0, 32'h0);
    cyc();
    chk("t6_fresh_only", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
